// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch / load-store) arbiter onto a single-outstanding memory bus.
// Data-side alignment faults are answered locally without touching the bus.
module mem_bus_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic [7:0]  data_op,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic [31:0] data_rdata,
  output logic        data_data_ok,
  output logic        data_adel,
  output logic        data_ades,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {StIdle, StAddr, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        grant_data_q, grant_data_d;
  logic        last_data_q, last_data_d;
  logic        wr_q, wr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic        dec_store;
  logic        dec_misalign;
  logic [3:0]  dec_wstrb;
  logic [31:0] dec_wdata;
  logic        pick_data;
  logic        idle_go;
  logic        fault;
  logic        grant_inst;
  logic        grant_data;
  logic [31:0] sel_addr;

  // Op decode; anything unrecognised behaves as LW.
  always_comb begin
    dec_store    = 1'b0;
    dec_misalign = |data_addr[1:0];
    dec_wstrb    = 4'b0000;
    dec_wdata    = 32'd0;
    case (data_op)
      EXE_LB_OP, EXE_LBU_OP: dec_misalign = 1'b0;
      EXE_LH_OP, EXE_LHU_OP: dec_misalign = data_addr[0];
      EXE_SB_OP: begin
        dec_store    = 1'b1;
        dec_misalign = 1'b0;
        dec_wstrb    = 4'b0001 << data_addr[1:0];
        dec_wdata    = {4{data_wdata[7:0]}};
      end
      EXE_SH_OP: begin
        dec_store    = 1'b1;
        dec_misalign = data_addr[0];
        dec_wstrb    = data_addr[1] ? 4'b1100 : 4'b0011;
        dec_wdata    = {2{data_wdata[15:0]}};
      end
      EXE_SW_OP: begin
        dec_store = 1'b1;
        dec_wstrb = 4'b1111;
        dec_wdata = data_wdata;
      end
      default: ;
    endcase
  end

  // Fairness: the side that did not complete last goes next when both ask.
  always_comb begin
    if (inst_req ^ data_req) begin
      pick_data = data_req;
    end else if (last_data_q) begin
      pick_data = 1'b0;
    end else if (data_req) begin
      pick_data = 1'b1;
    end else begin
      pick_data = DATA_FIRST;
    end
  end

  // Arbitration is gated by resetn so every output reads 0 while reset is held.
  assign idle_go    = (state_q == StIdle) && resetn;
  assign fault      = idle_go && data_req && dec_misalign;
  assign grant_inst = idle_go && !fault && inst_req && !pick_data;
  assign grant_data = idle_go && !fault && data_req && pick_data;
  assign sel_addr   = grant_data ? data_addr : inst_addr;

  always_comb begin
    state_d      = state_q;
    grant_data_d = grant_data_q;
    last_data_d  = last_data_q;
    wr_d         = wr_q;
    wstrb_d      = wstrb_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_inst || grant_data) begin
          state_d      = StAddr;
          grant_data_d = grant_data;
          wr_d         = grant_data && dec_store;
          wstrb_d      = grant_data ? dec_wstrb : 4'b0000;
          addr_d       = {sel_addr[31:2], 2'b00};
          wdata_d      = grant_data ? dec_wdata : 32'd0;
        end
      end
      StAddr: begin
        if (bus_addr_ok) state_d = StWait;
      end
      StWait: begin
        if (bus_data_ok) begin
          state_d = StResp;
          if (grant_data_q) data_rdata_d = bus_rdata;
          else              inst_rdata_d = bus_rdata;
        end
      end
      StResp: begin
        last_data_d = grant_data_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      grant_data_q <= 1'b0;
      last_data_q  <= 1'b0;
      wr_q         <= 1'b0;
      wstrb_q      <= 4'b0000;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      grant_data_q <= grant_data_d;
      last_data_q  <= last_data_d;
      wr_q         <= wr_d;
      wstrb_q      <= wstrb_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // Bus fields are only presented while the address phase is open.
  assign bus_req   = (state_q == StAddr);
  assign bus_wr    = bus_req && wr_q;
  assign bus_wstrb = bus_req ? wstrb_q : 4'b0000;
  assign bus_addr  = bus_req ? addr_q : 32'd0;
  assign bus_wdata = bus_req ? wdata_q : 32'd0;

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data || fault;
  assign inst_data_ok = (state_q == StResp) && !grant_data_q;
  assign data_data_ok = ((state_q == StResp) && grant_data_q) || fault;
  assign data_adel    = fault && !dec_store;
  assign data_ades    = fault && dec_store;
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised self-checking bench for mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam logic [7:0] LB  = 8'b1110_0000;
  localparam logic [7:0] LH  = 8'b1110_0001;
  localparam logic [7:0] LBU = 8'b1110_0100;
  localparam logic [7:0] LHU = 8'b1110_0101;
  localparam logic [7:0] SB  = 8'b1110_1000;
  localparam logic [7:0] SH  = 8'b1110_1001;
  localparam logic [7:0] SW  = 8'b1110_1011;
  localparam logic [7:0] LW  = 8'b1110_0011;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, data_req;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [7:0]  data_op;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, data_adel, data_ades;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  bit          last_data_m;
  logic [31:0] m_ird, m_drd;
  bit          m_drd_known;

  mem_bus_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_op(data_op), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .data_adel(data_adel), .data_ades(data_ades),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit is_store(input logic [7:0] op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic bit misaligned(input logic [7:0] op, input logic [31:0] a);
    if (op == LB || op == LBU || op == SB) return 1'b0;
    if (op == LH || op == LHU || op == SH) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [7:0] op, input logic [31:0] a);
    if (op == SW) return 4'hf;
    if (op == SH) return ((a % 4) >= 2) ? 4'hc : 4'h3;
    if (op == SB) return 4'(1 << (a % 4));
    return 4'h0;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [7:0] op, input logic [31:0] w);
    if (op == SW) return w;
    if (op == SH) return (w & 32'hffff) * 32'h0001_0001;
    if (op == SB) return (w & 32'hff) * 32'h0101_0101;
    return 32'd0;
  endfunction

  // flags = {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, adel, ades}
  function automatic logic [127:0] pack(input bit req, input bit wr, input logic [3:0] s,
                                        input logic [31:0] a, input logic [31:0] wd,
                                        input logic [5:0] flags);
    return {52'd0, req, wr, s, a, wd, flags};
  endfunction

  function automatic logic [127:0] outs();
    return {52'd0, bus_req, bus_wr, bus_wstrb, bus_addr, bus_wr ? bus_wdata : 32'd0,
            inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, data_adel, data_ades};
  endfunction

  task automatic clear_inputs();
    inst_req = 0; data_req = 0; inst_addr = 0; data_addr = 0; data_wdata = 0;
    data_op = LW; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    resetn = 0;
    #1;
    check_eq("reset_outs", outs(), pack(0, 0, 0, 0, 0, 6'b0));
    check_eq("reset_rdata", {inst_rdata, data_rdata}, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1;
    last_data_m = 0; m_ird = 0; m_drd = 0; m_drd_known = 1;
  endtask

  // One arbitration slot starting in IDLE. res: 0 none, 1 inst granted, 2 data granted, 3 fault.
  task automatic do_txn(input bit ir, input bit dr, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] w, input logic [31:0] ia, input int adly,
                        input int ddly, input logic [31:0] rd, output int res);
    bit gd, st;
    logic [31:0] wa, wd;
    logic [3:0] ws;
    @(negedge clk);
    inst_req = ir; inst_addr = ia; data_req = dr; data_op = op; data_addr = a; data_wdata = w;
    bus_addr_ok = 1'($urandom % 2); bus_data_ok = 1'($urandom % 2); bus_rdata = $urandom;
    #1;
    if (!ir && !dr) begin
      check_eq("idle_none", outs(), pack(0, 0, 0, 0, 0, 6'b0));
      res = 0;
      return;
    end
    if (dr && misaligned(op, a)) begin
      st = is_store(op);
      check_eq("fault", outs(), pack(0, 0, 0, 0, 0, {2'b01, 2'b01, !st, st}));
      res = 3;
      return;
    end
    gd = (ir && dr) ? !last_data_m : dr;
    check_eq("accept", outs(), pack(0, 0, 0, 0, 0, {!gd, gd, 4'b0}));
    st = gd && is_store(op);
    ws = gd ? exp_strb(op, a) : 4'h0;
    wd = st ? exp_wdata(op, w) : 32'd0;
    wa = gd ? {a[31:2], 2'b00} : {ia[31:2], 2'b00};
    for (int k = 0; k <= adly; k++) begin
      @(negedge clk);
      if (gd) begin
        data_req = 0; data_addr = $urandom; data_wdata = $urandom;
      end else begin
        inst_req = 0; inst_addr = $urandom;
      end
      bus_addr_ok = (k == adly); bus_data_ok = 0;
      #1;
      check_eq("addr_phase", outs(), pack(1, st, ws, wa, wd, 6'b0));
    end
    for (int k = 0; k <= ddly; k++) begin
      @(negedge clk);
      bus_addr_ok = 0; bus_data_ok = (k == ddly);
      bus_rdata = (k == ddly) ? rd : $urandom;
      #1;
      check_eq("wait_phase", outs(), pack(0, 0, 0, 0, 0, 6'b0));
    end
    @(negedge clk);
    bus_data_ok = 1'($urandom % 2); bus_addr_ok = 1'($urandom % 2); bus_rdata = $urandom;
    #1;
    check_eq("resp", outs(), pack(0, 0, 0, 0, 0, {2'b00, !gd, gd, 2'b00}));
    if (gd) begin
      check_eq("inst_rdata_hold", inst_rdata, m_ird);
      if (!st) begin
        check_eq("data_rdata", data_rdata, rd);
        m_drd = rd; m_drd_known = 1;
      end else begin
        m_drd_known = 0;
      end
    end else begin
      check_eq("inst_rdata", inst_rdata, rd);
      if (m_drd_known) check_eq("data_rdata_hold", data_rdata, m_drd);
      m_ird = rd;
    end
    last_data_m = gd;
    res = gd ? 2 : 1;
  endtask

  logic [7:0] op_tab [9];
  int res;
  int exp_seq [4];
  bit pi, pd;
  logic [7:0] r_op;
  logic [31:0] r_a, r_w, r_ia;

  initial begin
    op_tab = '{LB, LH, LBU, LHU, LW, SB, SH, SW, 8'h00};
    exp_seq = '{2, 1, 2, 1};
    resetn = 0;
    clear_inputs();
    do_reset();

    // Aligned word load, immediate slave.
    do_txn(0, 1, LW, 32'h100, 32'h0, 32'h0, 0, 0, 32'hDEAD_BEEF, res);
    check_eq("lw_grant", res, 2);
    // Byte / half stores and a misaligned half load.
    do_txn(0, 1, SB, 32'h203, 32'h0000_00A5, 32'h0, 0, 0, 32'h0, res);
    do_txn(0, 1, SH, 32'h202, 32'h0000_1234, 32'h0, 1, 2, 32'h0, res);
    do_txn(0, 1, LH, 32'h101, 32'h0, 32'h0, 0, 0, 32'h0, res);
    check_eq("lh_fault", res, 3);
    @(negedge clk);
    data_req = 0;
    #1;
    check_eq("fault_no_bus", outs(), pack(0, 0, 0, 0, 0, 6'b0));
    // Slave stalls the address phase; data-side inputs wiggle meanwhile.
    do_txn(0, 1, SW, 32'h3C0, 32'hCAFE_F00D, 32'h0, 4, 1, 32'h0, res);

    // Both masters held from reset: data first, then strict alternation.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_txn(1, 1, LW, 32'h400 + 32'(i * 4), 32'h0, 32'h800 + 32'(i * 4), 0, 0,
             $urandom, res);
      check_eq("alternate", res, exp_seq[i]);
    end

    // Reset while waiting for bus_data_ok; the late completion must be ignored.
    do_reset();
    @(negedge clk);
    data_req = 1; data_op = LW; data_addr = 32'h40;
    #1;
    check_eq("abandon_accept", outs(), pack(0, 0, 0, 0, 0, 6'b010000));
    @(negedge clk);
    data_req = 0; bus_addr_ok = 1;
    #1;
    check_eq("abandon_addr", outs(), pack(1, 0, 0, 32'h40, 0, 6'b0));
    @(negedge clk);
    bus_addr_ok = 0;
    #2;
    resetn = 0;
    #1;
    check_eq("abandon_rst", outs(), pack(0, 0, 0, 0, 0, 6'b0));
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
    bus_data_ok = 1; bus_rdata = 32'h5555_AAAA;
    #1;
    check_eq("stale_data_ok", outs(), pack(0, 0, 0, 0, 0, 6'b0));
    @(negedge clk);
    bus_data_ok = 0;
    #1;
    check_eq("stale_after", outs(), pack(0, 0, 0, 0, 0, 6'b0));
    check_eq("stale_rdata", {inst_rdata, data_rdata}, 64'd0);
    last_data_m = 0; m_ird = 0; m_drd = 0; m_drd_known = 1;

    // Random traffic; a losing request stays asserted with unchanged fields.
    pi = 0; pd = 0; r_op = LW; r_a = 0; r_w = 0; r_ia = 0;
    for (int n = 0; n < 80; n++) begin
      if (!pi) begin
        pi = 1'($urandom % 2);
        r_ia = {22'd0, 8'($urandom), 2'b00};
      end
      if (!pd) begin
        pd = 1'($urandom % 2);
        r_op = op_tab[$urandom % 9];
        r_a = {22'd1, 8'($urandom), 2'($urandom)};
        r_w = $urandom;
      end
      do_txn(pi, pd, r_op, r_a, r_w, r_ia, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom, res);
      if (res == 1) pi = 0;
      if (res == 2 || res == 3) pd = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
